// File: rtl/better_neighbors_in_my_cluster_pkg.sv
// Shared constants, memory map and FSM encoding for the
// better-neighbors-in-my-cluster scan.
package better_neighbors_in_my_cluster_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int ADDR_W     = 11;
  localparam int MAX_NBR    = 64;
  localparam int MAX_BN     = 16;

  localparam logic [ADDR_W-1:0] NID_BASE   = 11'h048;
  localparam logic [ADDR_W-1:0] CID_BASE   = 11'h0C8;
  localparam logic [ADDR_W-1:0] Q_BASE     = 11'h1C8;
  localparam logic [ADDR_W-1:0] BN_BASE    = 11'h668;
  localparam logic [ADDR_W-1:0] NCNT_ADDR  = 11'h68A;
  localparam logic [ADDR_W-1:0] BNCNT_ADDR = 11'h68C;
  localparam logic [ADDR_W-1:0] SINK_BASE  = 11'h68E;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_CNT,
    S_RD_CID,
    S_RD_Q,
    S_RD_NID,
    S_WR_BN,
    S_NEXT,
    S_WR_CNT,
    S_RD_SINK,
    S_DONE
  } state_t;

  function automatic logic [ADDR_W-1:0] word_addr(
    input logic [ADDR_W-1:0] base,
    input logic [6:0]        idx
  );
    return base + {3'b000, idx, 1'b0};
  endfunction

endpackage

// File: rtl/better_neighbors_in_my_cluster_if.sv
// Single-port memory bus between the scan block (master)
// and the shared word memory (slave).
interface better_neighbors_in_my_cluster_if;
  import better_neighbors_in_my_cluster_pkg::*;

  logic [ADDR_W-1:0]     address;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] mem_data_in;
  logic [WORD_WIDTH-1:0] mem_data_out;

  modport master (
    output address,
    output wr_en,
    output mem_data_in,
    input  mem_data_out
  );

  modport slave (
    input  address,
    input  wr_en,
    input  mem_data_in,
    output mem_data_out
  );

endinterface

// File: rtl/better_neighbors_in_my_cluster_mem.sv
// Shared 2 KiB memory, 1024 x 16-bit words, byte-addressed:
// combinational read, synchronous write.
module better_neighbors_in_my_cluster_mem
  import better_neighbors_in_my_cluster_pkg::*;
(
  input logic clock,
  better_neighbors_in_my_cluster_if.slave bus
);

  logic [WORD_WIDTH-1:0] mem [1024];
  logic                  unused_lsb;

  assign unused_lsb = bus.address[0];

  always_ff @(posedge clock) begin
    if (bus.wr_en) mem[bus.address[10:1]] <= bus.mem_data_in;
  end

  assign bus.mem_data_out = mem[bus.address[10:1]];

endmodule

// File: rtl/better_neighbors_in_my_cluster.sv
// Neighbor-table scan for better in-cluster neighbors.
// Define BNIMC_WRITEBACK_EN to write results back to memory.
module better_neighbors_in_my_cluster
  import better_neighbors_in_my_cluster_pkg::*;
(
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  done_findMyBest,
  better_neighbors_in_my_cluster_if.master mem_bus,
  input  logic [WORD_WIDTH-1:0] MY_CLUSTER_ID,
  input  logic [WORD_WIDTH-1:0] mybest,
  output logic [WORD_WIDTH-1:0] besthop,
  output logic [WORD_WIDTH-1:0] bestvalue,
  output logic [WORD_WIDTH-1:0] bestneighborID,
  output logic [WORD_WIDTH-1:0] nextsinks,
  output logic                  done_betterNeighborsInMyCluster
);

`ifdef BNIMC_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  state_t state, nstate;

  logic [6:0] cnt, idx, k;
  logic [6:0] idx_nxt, k_sat, cnt_clamp;
  logic [WORD_WIDTH-1:0] hb, vb, nb, nid_cur, rd;
  logic upd, go, qual, has_best, enter_done;

  assign rd        = mem_bus.mem_data_out;
  assign go        = en & done_findMyBest;
  assign qual      = rd < mybest;
  assign idx_nxt   = idx + 7'd1;
  assign has_best  = (hb != '1);
  assign k_sat     = (k > 7'(MAX_BN)) ? 7'(MAX_BN) : k;
  assign cnt_clamp = (rd > 16'(MAX_NBR)) ? 7'(MAX_NBR)
                                         : rd[6:0];
  assign enter_done = (nstate == S_DONE) && (state != S_DONE);
  assign done_betterNeighborsInMyCluster = (state == S_DONE);

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      idx            <= '0;
      k              <= '0;
      hb             <= '0;
      vb             <= '0;
      nb             <= '0;
      nid_cur        <= '0;
      upd            <= 1'b0;
      besthop        <= '0;
      bestvalue      <= '0;
      bestneighborID <= '0;
      nextsinks      <= '0;
    end else begin
      state <= nstate;
      unique case (state)
        S_RD_CNT: begin
          cnt <= cnt_clamp;
          idx <= '0;
          k   <= '0;
          hb  <= '1;
          nb  <= '1;
          vb  <= mybest;
          upd <= 1'b0;
        end
        S_RD_Q: begin
          // strict < keeps the earlier index on ties
          if (qual && rd < vb) begin
            vb  <= rd;
            hb  <= {9'b0, idx};
            upd <= 1'b1;
          end else begin
            upd <= 1'b0;
          end
        end
        S_RD_NID: begin
          nid_cur <= rd;
          if (upd) nb <= rd;
        end
        S_WR_BN: k   <= k + 7'd1;
        S_NEXT:  idx <= idx_nxt;
        default: ;
      endcase
      if (enter_done) begin
        besthop        <= hb;
        bestvalue      <= vb;
        bestneighborID <= nb;
        nextsinks      <= (state == S_RD_SINK) ? rd : '0;
      end
    end
  end

  always_comb begin
    nstate              = state;
    mem_bus.address     = '0;
    mem_bus.wr_en       = 1'b0;
    mem_bus.mem_data_in = '0;
    unique case (state)
      S_IDLE: if (go) nstate = S_RD_CNT;
      S_RD_CNT: begin
        mem_bus.address = NCNT_ADDR;
        nstate = (rd == '0) ? S_WR_CNT : S_RD_CID;
      end
      S_RD_CID: begin
        mem_bus.address = word_addr(CID_BASE, idx);
        nstate = (rd == MY_CLUSTER_ID) ? S_RD_Q : S_NEXT;
      end
      S_RD_Q: begin
        mem_bus.address = word_addr(Q_BASE, idx);
        nstate = qual ? S_RD_NID : S_NEXT;
      end
      S_RD_NID: begin
        mem_bus.address = word_addr(NID_BASE, idx);
        nstate = S_WR_BN;
      end
      S_WR_BN: begin
        mem_bus.address     = word_addr(BN_BASE, k);
        mem_bus.mem_data_in = nid_cur;
        mem_bus.wr_en       = WB_EN && (k < 7'(MAX_BN));
        nstate = S_NEXT;
      end
      S_NEXT: nstate = (idx_nxt == cnt) ? S_WR_CNT : S_RD_CID;
      S_WR_CNT: begin
        mem_bus.address     = BNCNT_ADDR;
        mem_bus.mem_data_in = {9'b0, k_sat};
        mem_bus.wr_en       = WB_EN;
        nstate = has_best ? S_RD_SINK : S_DONE;
      end
      S_RD_SINK: begin
        mem_bus.address = word_addr(SINK_BASE, hb[6:0]);
        nstate = S_DONE;
      end
      S_DONE: if (!go) nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_better_neighbors_in_my_cluster.sv
// Directed bench: vector table of neighbor tables plus
// hand sequences for overflow, clamp, hold and reset.
module tb_better_neighbors_in_my_cluster;
  import better_neighbors_in_my_cluster_pkg::*;

`ifdef BNIMC_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  typedef logic [3:0][15:0] quad_t;

  typedef struct {
    int          cnt;
    logic [15:0] my_cid;
    logic [15:0] mybest;
    quad_t       cid;
    quad_t       q;
    quad_t       nid;
    quad_t       sink;
    logic [15:0] e_hop;
    logic [15:0] e_val;
    logic [15:0] e_nid;
    logic [15:0] e_sinks;
    int          e_k;
    quad_t       e_bn;
    int          e_cyc;
  } vec_t;

  logic        clock = 1'b0;
  logic        nrst, en, done_fm, done;
  logic [15:0] my_cid, mybest;
  logic [15:0] besthop, bestvalue, bestnid, nextsinks;
  logic        ld_mode, ld_we;
  logic [10:0] ld_addr;
  logic [15:0] ld_data;
  int          tests = 0;
  int          fails = 0;
  int          wr_seen = 0;
  vec_t        vecs[7];

  always #5 clock = ~clock;

  better_neighbors_in_my_cluster_if dbus ();
  better_neighbors_in_my_cluster_if mbus ();

  assign mbus.address     = ld_mode ? ld_addr : dbus.address;
  assign mbus.wr_en       = ld_mode ? ld_we : dbus.wr_en;
  assign mbus.mem_data_in = ld_mode ? ld_data
                                    : dbus.mem_data_in;
  assign dbus.mem_data_out = mbus.mem_data_out;

  better_neighbors_in_my_cluster_mem u_mem (
    .clock (clock),
    .bus   (mbus)
  );

  better_neighbors_in_my_cluster dut (
    .clock                           (clock),
    .nrst                            (nrst),
    .en                              (en),
    .done_findMyBest                 (done_fm),
    .mem_bus                         (dbus),
    .MY_CLUSTER_ID                   (my_cid),
    .mybest                          (mybest),
    .besthop                         (besthop),
    .bestvalue                       (bestvalue),
    .bestneighborID                  (bestnid),
    .nextsinks                       (nextsinks),
    .done_betterNeighborsInMyCluster (done)
  );

  always @(negedge clock) begin
    if (!ld_mode && dbus.wr_en) wr_seen++;
  end

  function automatic quad_t pk(
    input logic [15:0] a, b, c, d
  );
    return {d, c, b, a};
  endfunction

  function automatic vec_t mk(
    input int cnt, input logic [15:0] mc, mb,
    input quad_t cid, q, nid, sink,
    input logic [15:0] h, v, n, s,
    input int k, input quad_t bn, input int cyc
  );
    vec_t r;
    r.cnt = cnt;  r.my_cid = mc; r.mybest = mb;
    r.cid = cid;  r.q = q; r.nid = nid; r.sink = sink;
    r.e_hop = h;  r.e_val = v; r.e_nid = n;
    r.e_sinks = s; r.e_k = k; r.e_bn = bn; r.e_cyc = cyc;
    return r;
  endfunction

  function automatic int sat16(input int k);
    return (k > 16) ? 16 : k;
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic wr_mem(
    input logic [10:0] a, input logic [15:0] d
  );
    ld_addr = a;
    ld_data = d;
    ld_we   = 1'b1;
    @(posedge clock);
    #1;
    ld_we = 1'b0;
  endtask

  task automatic rd_mem(
    input logic [10:0] a, output logic [15:0] d
  );
    ld_addr = a;
    #1;
    d = mbus.mem_data_out;
  endtask

  task automatic clear_mem();
    ld_mode = 1'b1;
    for (int i = 0; i < 1024; i++)
      wr_mem(11'(i * 2), 16'h0);
  endtask

  task automatic scan(
    input string nm, input int limit,
    output int cyc, output int wrs
  );
    int w0;
    ld_mode = 1'b0;
    w0 = wr_seen;
    en = 1'b1;
    done_fm = 1'b1;
    cyc = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
    end while (!done && cyc < limit);
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: done=0 after %0d cycles",
               nm, cyc);
    end
    wrs = wr_seen - w0;
  endtask

  task automatic drop_en(input string nm);
    ld_mode = 1'b1;
    en = 1'b0;
    @(posedge clock);
    #1;
    chk({nm, " done drop"}, 32'(done), 32'd0);
  endtask

  task automatic load_vec(input vec_t v);
    clear_mem();
    wr_mem(NCNT_ADDR, 16'(v.cnt));
    for (int j = 0; j < 4; j++) begin
      wr_mem(CID_BASE + 11'(2 * j), v.cid[j]);
      wr_mem(Q_BASE + 11'(2 * j), v.q[j]);
      wr_mem(NID_BASE + 11'(2 * j), v.nid[j]);
      wr_mem(SINK_BASE + 11'(2 * j), v.sink[j]);
    end
    my_cid = v.my_cid;
    mybest = v.mybest;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int cyc, wrs;
    logic [15:0] d;
    string nm;
    nm = $sformatf("v%0d", n);
    load_vec(v);
    scan(nm, 400, cyc, wrs);
    chk({nm, " cycles"}, 32'(cyc), 32'(v.e_cyc));
    chk({nm, " besthop"}, 32'(besthop), 32'(v.e_hop));
    chk({nm, " bestvalue"}, 32'(bestvalue), 32'(v.e_val));
    chk({nm, " bestnid"}, 32'(bestnid), 32'(v.e_nid));
    chk({nm, " nextsinks"}, 32'(nextsinks),
        32'(v.e_sinks));
    chk({nm, " writes"}, 32'(wrs),
        WB ? 32'(sat16(v.e_k) + 1) : 32'd0);
    ld_mode = 1'b1;
    rd_mem(BNCNT_ADDR, d);
    chk({nm, " bncount"}, 32'(d),
        WB ? 32'(sat16(v.e_k)) : 32'd0);
    for (int j = 0; j < 4; j++) begin
      rd_mem(BN_BASE + 11'(2 * j), d);
      chk($sformatf("%s bn[%0d]", nm, j), 32'(d),
          (WB && j < v.e_k) ? 32'(v.e_bn[j]) : 32'd0);
    end
    drop_en(nm);
  endtask

  initial begin
    int cyc, wrs, hi_cnt;
    logic [15:0] d;

    vecs[0] = mk(0, 16'd1, 16'h1234,
      pk(0, 0, 0, 0), pk(0, 0, 0, 0),
      pk(0, 0, 0, 0), pk(0, 0, 0, 0),
      16'hFFFF, 16'h1234, 16'hFFFF, 16'd0,
      0, pk(0, 0, 0, 0), 3);
    vecs[1] = mk(4, 16'd1, 16'h1140,
      pk(1, 2, 1, 1),
      pk(16'h1000, 16'h0800, 16'h1140, 16'h0F00),
      pk(10, 11, 12, 13), pk(0, 0, 0, 2),
      16'd3, 16'h0F00, 16'd13, 16'd2,
      2, pk(10, 13, 0, 0), 19);
    vecs[2] = mk(3, 16'd1, 16'h0800,
      pk(1, 1, 1, 0),
      pk(16'h0500, 16'h0600, 16'h0500, 0),
      pk(20, 21, 22, 0), pk(7, 0, 9, 0),
      16'd0, 16'h0500, 16'd20, 16'd7,
      3, pk(20, 21, 22, 0), 19);
    vecs[3] = mk(2, 16'd1, 16'h0900,
      pk(1, 1, 0, 0), pk(16'h0900, 16'hFFFF, 0, 0),
      pk(30, 31, 0, 0), pk(4, 4, 0, 0),
      16'hFFFF, 16'h0900, 16'hFFFF, 16'd0,
      0, pk(0, 0, 0, 0), 9);
    vecs[4] = mk(1, 16'd1, 16'h0000,
      pk(1, 0, 0, 0), pk(0, 0, 0, 0),
      pk(5, 0, 0, 0), pk(6, 0, 0, 0),
      16'hFFFF, 16'h0000, 16'hFFFF, 16'd0,
      0, pk(0, 0, 0, 0), 6);
    vecs[5] = mk(4, 16'h8001, 16'hFFFF,
      pk(1, 3, 16'h0001, 16'h8000), pk(0, 0, 0, 0),
      pk(1, 2, 3, 4), pk(1, 1, 1, 1),
      16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0,
      0, pk(0, 0, 0, 0), 11);
    vecs[6] = mk(4, 16'hABCD, 16'h8000,
      pk(16'hABCC, 16'hABCD, 16'hABCD, 16'hABCD),
      pk(0, 16'h7FFF, 16'h8000, 16'h0001),
      pk(40, 41, 42, 43), pk(0, 5, 6, 8),
      16'd3, 16'h0001, 16'd43, 16'd8,
      2, pk(41, 43, 0, 0), 19);

    nrst = 1'b0;
    en = 1'b0;
    done_fm = 1'b0;
    ld_mode = 1'b1;
    ld_we = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    my_cid = '0;
    mybest = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset besthop", 32'(besthop), 32'd0);
    chk("reset bestvalue", 32'(bestvalue), 32'd0);
    chk("reset bestnid", 32'(bestnid), 32'd0);
    chk("reset nextsinks", 32'(nextsinks), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset wr_en", 32'(dbus.wr_en), 32'd0);
    nrst = 1'b1;

    for (int n = 0; n < 7; n++) run_vec(n, vecs[n]);

    // 20 qualifiers: only 16 IDs stored, count saturates
    clear_mem();
    wr_mem(NCNT_ADDR, 16'd20);
    for (int i = 0; i < 20; i++) begin
      wr_mem(CID_BASE + 11'(2 * i), 16'd1);
      wr_mem(Q_BASE + 11'(2 * i), 16'(16'h200 - i));
      wr_mem(NID_BASE + 11'(2 * i), 16'(100 + i));
    end
    wr_mem(SINK_BASE + 11'(38), 16'd5);
    my_cid = 16'd1;
    mybest = 16'h1000;
    scan("ovf", 400, cyc, wrs);
    chk("ovf cycles", 32'(cyc), 32'd104);
    chk("ovf besthop", 32'(besthop), 32'd19);
    chk("ovf bestvalue", 32'(bestvalue), 32'h1ED);
    chk("ovf bestnid", 32'(bestnid), 32'd119);
    chk("ovf nextsinks", 32'(nextsinks), 32'd5);
    chk("ovf writes", 32'(wrs), WB ? 32'd17 : 32'd0);
    ld_mode = 1'b1;
    rd_mem(BNCNT_ADDR, d);
    chk("ovf bncount", 32'(d), WB ? 32'd16 : 32'd0);
    for (int j = 0; j < 17; j++) begin
      rd_mem(BN_BASE + 11'(2 * j), d);
      chk($sformatf("ovf bn[%0d]", j), 32'(d),
          (WB && j < 16) ? 32'(100 + j) : 32'd0);
    end
    drop_en("ovf");

    // count 65 clamps to 64; entry 64 would qualify
    clear_mem();
    wr_mem(NCNT_ADDR, 16'd65);
    wr_mem(CID_BASE + 11'(128), 16'd1);
    wr_mem(NID_BASE + 11'(128), 16'd77);
    my_cid = 16'd1;
    mybest = 16'h0010;
    scan("clamp", 400, cyc, wrs);
    chk("clamp cycles", 32'(cyc), 32'd131);
    chk("clamp besthop", 32'(besthop), 32'hFFFF);
    chk("clamp bestvalue", 32'(bestvalue), 32'h0010);

    // hold in DONE: no rescan, outputs frozen
    mybest = 16'h0022;
    hi_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      if (done) hi_cnt++;
    end
    chk("hold done cycles", 32'(hi_cnt), 32'd5);
    chk("hold bestvalue", 32'(bestvalue), 32'h0010);
    drop_en("hold");
    scan("rescan", 400, cyc, wrs);
    chk("rescan cycles", 32'(cyc), 32'd131);
    chk("rescan bestvalue", 32'(bestvalue), 32'h0022);
    drop_en("rescan");

    // reset mid-scan, then a clean restart
    load_vec(vecs[1]);
    ld_mode = 1'b0;
    en = 1'b1;
    done_fm = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    nrst = 1'b0;
    en = 1'b0;
    #1;
    chk("abort besthop", 32'(besthop), 32'd0);
    chk("abort bestvalue", 32'(bestvalue), 32'd0);
    chk("abort bestnid", 32'(bestnid), 32'd0);
    chk("abort nextsinks", 32'(nextsinks), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort address", 32'(dbus.address), 32'd0);
    @(posedge clock);
    #1;
    nrst = 1'b1;
    scan("restart", 400, cyc, wrs);
    chk("restart cycles", 32'(cyc), 32'd19);
    chk("restart besthop", 32'(besthop), 32'd3);
    chk("restart bestvalue", 32'(bestvalue), 32'h0F00);
    chk("restart bestnid", 32'(bestnid), 32'd13);
    chk("restart nextsinks", 32'(nextsinks), 32'd2);
    drop_en("restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
